// File: rtl/pll_mgmt_slave.sv
// Behavioural PLL reconfiguration responder: shadow/active register sets, a
// RECONF/LOCKWAIT sequencer and the mgmt_waitrequest handshake.
module pll_mgmt_slave #(
  parameter int unsigned RECONF_CYCLES = 16,
  parameter int unsigned LOCK_CYCLES   = 64,
  parameter logic [31:0] N_RST         = 32'h00010000,
  parameter logic [31:0] M_RST         = 32'h00000404,
  parameter logic [17:0] C0_RST        = 18'h00505,
  parameter logic [31:0] MFRAC_RST     = 32'h9745BF27
) (
  input  logic        mgmt_clk,
  input  logic        mgmt_reset,
  input  logic        mgmt_write,
  input  logic        mgmt_read,
  input  logic [5:0]  mgmt_address,
  input  logic [31:0] mgmt_writedata,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  output logic [31:0] cfg_n,
  output logic [31:0] cfg_m,
  output logic [31:0] cfg_mfrac,
  output logic [17:0] cfg_c0,
  output logic [17:0] cfg_c1,
  output logic [17:0] cfg_c2,
  output logic [17:0] cfg_c3,
  output logic        cfg_update,
  output logic        locked
);

  localparam int unsigned CntMax = (RECONF_CYCLES > LOCK_CYCLES) ? RECONF_CYCLES : LOCK_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] ReconfLoad = CntW'(RECONF_CYCLES - 1);
  localparam logic [CntW-1:0] LockLoad   = CntW'(LOCK_CYCLES - 1);

  localparam logic [5:0] AddrMode   = 6'd0;
  localparam logic [5:0] AddrStatus = 6'd1;
  localparam logic [5:0] AddrStart  = 6'd2;
  localparam logic [5:0] AddrN      = 6'd3;
  localparam logic [5:0] AddrM      = 6'd4;
  localparam logic [5:0] AddrC      = 6'd5;
  localparam logic [5:0] AddrMfrac  = 6'd7;

  typedef enum logic [1:0] {StIdle, StReconf, StLockWait} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            mode_q, start_pending_q, locked_q, cfg_update_q;
  logic [31:0]     n_sh_q, m_sh_q, mfrac_sh_q, n_q, m_q, mfrac_q;
  logic [17:0]     c0_sh_q, c1_sh_q, c2_sh_q, c3_sh_q, c0_q, c1_q, c2_q, c3_q;

  logic        stall, wr_acc, rd_acc, start_acc;
  logic [4:0]  c_sel;
  logic        unused_wd;

  assign c_sel     = mgmt_writedata[22:18];
  assign unused_wd = ^mgmt_writedata[31:23];

  // Polling mode lets STATUS reads through so the master can watch for idle.
  always_comb begin
    stall = 1'b0;
    if (state_q == StReconf) begin
      if (mode_q) begin
        stall = !(mgmt_read && !mgmt_write && (mgmt_address == AddrStatus));
      end else begin
        stall = !((cnt_q == '0) && start_pending_q);
      end
    end
  end

  assign mgmt_waitrequest = (mgmt_write | mgmt_read) & stall;
  assign wr_acc           = mgmt_write & ~stall;
  assign rd_acc           = mgmt_read & ~mgmt_write & ~stall;
  assign start_acc        = wr_acc & (mgmt_address == AddrStart);

  always_comb begin
    mgmt_readdata = '0;
    if (rd_acc) begin
      case (mgmt_address)
        AddrMode:   mgmt_readdata = {31'b0, mode_q};
        AddrStatus: mgmt_readdata = {30'b0, locked_q, state_q == StIdle};
        AddrN:      mgmt_readdata = n_sh_q;
        AddrM:      mgmt_readdata = m_sh_q;
        AddrC:      mgmt_readdata = {14'b0, c0_sh_q};
        AddrMfrac:  mgmt_readdata = mfrac_sh_q;
        default:    mgmt_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge mgmt_clk) begin
    if (mgmt_reset) begin
      state_q         <= StLockWait;
      cnt_q           <= LockLoad;
      mode_q          <= 1'b0;
      start_pending_q <= 1'b0;
      locked_q        <= 1'b0;
      cfg_update_q    <= 1'b0;
      n_sh_q          <= N_RST;
      m_sh_q          <= M_RST;
      mfrac_sh_q      <= MFRAC_RST;
      c0_sh_q         <= C0_RST;
      c1_sh_q         <= '0;
      c2_sh_q         <= '0;
      c3_sh_q         <= '0;
      n_q             <= N_RST;
      m_q             <= M_RST;
      mfrac_q         <= MFRAC_RST;
      c0_q            <= C0_RST;
      c1_q            <= '0;
      c2_q            <= '0;
      c3_q            <= '0;
    end else begin
      cfg_update_q <= 1'b0;
      if (wr_acc) begin
        case (mgmt_address)
          AddrMode:  mode_q     <= mgmt_writedata[0];
          AddrN:     n_sh_q     <= mgmt_writedata;
          AddrM:     m_sh_q     <= mgmt_writedata;
          AddrMfrac: mfrac_sh_q <= mgmt_writedata;
          AddrC: begin
            case (c_sel)
              5'd0:    c0_sh_q <= mgmt_writedata[17:0];
              5'd1:    c1_sh_q <= mgmt_writedata[17:0];
              5'd2:    c2_sh_q <= mgmt_writedata[17:0];
              5'd3:    c3_sh_q <= mgmt_writedata[17:0];
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      unique case (state_q)
        StIdle, StLockWait: begin
          if (start_acc) begin
            state_q         <= StReconf;
            cnt_q           <= ReconfLoad;
            locked_q        <= 1'b0;
            start_pending_q <= ~mode_q;
          end else if (state_q == StLockWait) begin
            if (cnt_q == '0) begin
              locked_q <= 1'b1;
              state_q  <= StIdle;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        StReconf: begin
          // A START completing here is the held one; it never retriggers.
          if (cnt_q == '0) begin
            n_q             <= n_sh_q;
            m_q             <= m_sh_q;
            mfrac_q         <= mfrac_sh_q;
            c0_q            <= c0_sh_q;
            c1_q            <= c1_sh_q;
            c2_q            <= c2_sh_q;
            c3_q            <= c3_sh_q;
            cfg_update_q    <= 1'b1;
            cnt_q           <= LockLoad;
            start_pending_q <= 1'b0;
            state_q         <= StLockWait;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StLockWait;
      endcase
    end
  end

  assign cfg_n      = n_q;
  assign cfg_m      = m_q;
  assign cfg_mfrac  = mfrac_q;
  assign cfg_c0     = c0_q;
  assign cfg_c1     = c1_q;
  assign cfg_c2     = c2_q;
  assign cfg_c3     = c3_q;
  assign cfg_update = cfg_update_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_pll_mgmt_slave.sv
// Self-checking bench for pll_mgmt_slave: register table, waitrequest/polling
// START sequences, START during lock wait and reset mid-reconfiguration.
module tb_pll_mgmt_slave;

  localparam int R = 16;
  localparam int L = 64;

  logic        mgmt_clk = 1'b0;
  logic        mgmt_reset, mgmt_write, mgmt_read;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata, mgmt_readdata;
  logic        mgmt_waitrequest;
  logic [31:0] cfg_n, cfg_m, cfg_mfrac;
  logic [17:0] cfg_c0, cfg_c1, cfg_c2, cfg_c3;
  logic        cfg_update, locked;

  pll_mgmt_slave #(
    .RECONF_CYCLES(R),
    .LOCK_CYCLES  (L)
  ) dut (
    .mgmt_clk        (mgmt_clk),
    .mgmt_reset      (mgmt_reset),
    .mgmt_write      (mgmt_write),
    .mgmt_read       (mgmt_read),
    .mgmt_address    (mgmt_address),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_readdata   (mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest),
    .cfg_n           (cfg_n),
    .cfg_m           (cfg_m),
    .cfg_mfrac       (cfg_mfrac),
    .cfg_c0          (cfg_c0),
    .cfg_c1          (cfg_c1),
    .cfg_c2          (cfg_c2),
    .cfg_c3          (cfg_c3),
    .cfg_update      (cfg_update),
    .locked          (locked)
  );

  always #5 mgmt_clk = ~mgmt_clk;

  int cyc = 0;
  int upd_n = 0;
  int upd_cyc = -1;
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb[$];

  always @(posedge mgmt_clk) cyc <= cyc + 1;
  always @(negedge mgmt_clk) begin
    if (cfg_update) begin
      upd_n   = upd_n + 1;
      upd_cyc = cyc;
    end
  end

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_access(input logic wr, input logic rd, input logic [5:0] a,
                            input logic [31:0] wd, input logic [31:0] exp, input string nm,
                            output int waits, output int acc);
    logic [31:0] e;
    bit ok;
    ok    = 1'b0;
    waits = 0;
    e     = '0;
    if (rd) sb.push_back(exp);
    mgmt_write     = wr;
    mgmt_read      = rd;
    mgmt_address   = a;
    mgmt_writedata = wd;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge mgmt_clk);
      if (!mgmt_waitrequest) ok = 1'b1;
      else begin
        waits++;
        @(posedge mgmt_clk);
        #1;
      end
    end
    if (rd) e = sb.pop_front();
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: access not accepted within 200 cycles", nm);
    end else if (rd) begin
      chk(nm, mgmt_readdata, e);
    end
    @(posedge mgmt_clk);
    #1;
    acc        = cyc;
    mgmt_write = 1'b0;
    mgmt_read  = 1'b0;
  endtask

  // START held across the whole stall, as a waitrequest-mode master does.
  task automatic start_held(output int waits, output int acc, output int done);
    waits          = 0;
    done           = -1;
    mgmt_write     = 1'b1;
    mgmt_address   = 6'd2;
    mgmt_writedata = 32'h0;
    @(negedge mgmt_clk);
    chk("start_first_wr", {31'b0, mgmt_waitrequest}, 32'd0);
    @(posedge mgmt_clk);
    #1;
    acc = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge mgmt_clk);
      if (i == 0) chk("locked_cleared", {31'b0, locked}, 32'd0);
      if (!mgmt_waitrequest) begin
        done = cyc;
        break;
      end
      waits++;
    end
    if (done < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL start_held: held START never completed");
    end
    @(posedge mgmt_clk);
    #1;
    mgmt_write = 1'b0;
  endtask

  task automatic wait_lock(input string nm, output int at);
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge mgmt_clk);
      if (locked) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: locked never rose", nm);
    end
    @(posedge mgmt_clk);
    #1;
  endtask

  initial begin
    int w, a, a2, d, at, rel, base;
    mgmt_reset     = 1'b1;
    mgmt_write     = 1'b0;
    mgmt_read      = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;

    vecs[0]  = '{1'b1, 1'b0, 6'd0,  32'h00000000, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 6'd3,  32'h00010000, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 6'd4,  32'h00000404, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 6'd5,  32'h00020504, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 6'd5,  32'h00040ABC, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 6'd5,  32'h000F0001, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 6'd7,  32'hA3D709E8, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 6'd3,  32'h0, 32'h00010000};
    vecs[8]  = '{1'b0, 1'b1, 6'd4,  32'h0, 32'h00000404};
    vecs[9]  = '{1'b0, 1'b1, 6'd5,  32'h0, 32'h00020504};
    vecs[10] = '{1'b0, 1'b1, 6'd7,  32'h0, 32'hA3D709E8};
    vecs[11] = '{1'b1, 1'b0, 6'd5,  32'h0017FFFF, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 6'd5,  32'h0, 32'h00020504};
    vecs[13] = '{1'b1, 1'b0, 6'd6,  32'hDEADBEEF, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 6'd6,  32'h0, 32'h0};
    vecs[15] = '{1'b1, 1'b1, 6'd3,  32'h00010000, 32'h0};
    vecs[16] = '{1'b0, 1'b1, 6'd1,  32'h0, 32'h3};
    vecs[17] = '{1'b0, 1'b1, 6'd0,  32'h0, 32'h0};
    vecs[18] = '{1'b0, 1'b1, 6'd63, 32'h0, 32'h0};

    // Reset state.
    repeat (3) @(posedge mgmt_clk);
    @(negedge mgmt_clk);
    chk("rst_waitreq", {31'b0, mgmt_waitrequest}, 32'd0);
    chk("rst_readdata", mgmt_readdata, 32'h0);
    chk("rst_update", {31'b0, cfg_update}, 32'd0);
    chk("rst_locked", {31'b0, locked}, 32'd0);
    chk("rst_cfg_n", cfg_n, 32'h00010000);
    chk("rst_cfg_m", cfg_m, 32'h00000404);
    chk("rst_cfg_mfrac", cfg_mfrac, 32'h9745BF27);
    chk("rst_cfg_c0", {14'b0, cfg_c0}, 32'h505);
    chk("rst_cfg_c1", {14'b0, cfg_c1}, 32'h0);
    @(posedge mgmt_clk);
    #1;
    mgmt_reset = 1'b0;
    rel = cyc;
    bus_access(1'b0, 1'b1, 6'd1, 32'h0, 32'h0, "status_lockwait", w, a);
    wait_lock("reset_lock", at);
    chk("reset_lock_cycle", at, rel + L);
    bus_access(1'b0, 1'b1, 6'd1, 32'h0, 32'h3, "status_idle_locked", w, a);

    // Register table in IDLE, waitrequest mode.
    for (int i = 0; i < 19; i++) begin
      bus_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
                 $sformatf("vec%0d_rd", i), w, a);
      chk($sformatf("vec%0d_nostall", i), w, 0);
    end
    chk("shadow_no_effect_c0", {14'b0, cfg_c0}, 32'h505);
    chk("shadow_no_effect_mfrac", cfg_mfrac, 32'h9745BF27);

    // Waitrequest-mode START (PAL set).
    base = upd_n;
    start_held(w, a, d);
    chk("held_stall_cycles", w, R - 1);
    chk("held_done_cycle", d, a + R - 1);
    bus_access(1'b0, 1'b1, 6'd1, 32'h0, 32'h0, "no_retrigger_status", w, a2);
    chk("no_retrigger_stall", w, 0);
    wait_lock("pal_lock", at);
    chk("pal_update_count", upd_n, base + 1);
    chk("pal_update_cycle", upd_cyc, a + R);
    chk("pal_lock_cycle", at, a + R + L);
    chk("pal_c0", {14'b0, cfg_c0}, 32'h20504);
    chk("pal_c1", {14'b0, cfg_c1}, 32'h00ABC);
    chk("pal_c2", {14'b0, cfg_c2}, 32'h0);
    chk("pal_c3", {14'b0, cfg_c3}, 32'h30001);
    chk("pal_mfrac", cfg_mfrac, 32'hA3D709E8);

    // Polling mode: START, STATUS during RECONF, M write stalls to LOCKWAIT.
    base = upd_n;
    bus_access(1'b1, 1'b0, 6'd0, 32'h1, 32'h0, "mode_poll", w, a);
    bus_access(1'b1, 1'b0, 6'd2, 32'h0, 32'h0, "poll_start", w, a);
    chk("poll_start_nostall", w, 0);
    bus_access(1'b0, 1'b1, 6'd1, 32'h0, 32'h0, "poll_status_reconf", w, a2);
    chk("poll_status_nostall", w, 0);
    bus_access(1'b1, 1'b0, 6'd4, 32'h00000505, 32'h0, "poll_m_write", w, a2);
    chk("poll_m_stall", w, R - 1);
    chk("poll_m_accept_cycle", a2, a + R + 1);
    chk("poll_m_active_old", cfg_m, 32'h00000404);
    bus_access(1'b0, 1'b1, 6'd4, 32'h0, 32'h00000505, "poll_m_shadow", w, a2);
    bus_access(1'b0, 1'b1, 6'd1, 32'h0, 32'h0, "poll_status_lockwait", w, a2);

    // START accepted in LOCKWAIT restarts reconfiguration and lock time.
    bus_access(1'b1, 1'b0, 6'd2, 32'h0, 32'h0, "lw_start", w, a);
    wait_lock("lw_lock", at);
    chk("lw_update_count", upd_n, base + 2);
    chk("lw_update_cycle", upd_cyc, a + R);
    chk("lw_lock_cycle", at, a + R + L);
    chk("lw_cfg_m", cfg_m, 32'h00000505);

    // Reset mid-RECONF aborts the update.
    bus_access(1'b1, 1'b0, 6'd2, 32'h0, 32'h0, "abort_start", w, a);
    repeat (5) @(posedge mgmt_clk);
    #1;
    mgmt_reset = 1'b1;
    repeat (2) @(posedge mgmt_clk);
    #1;
    mgmt_reset = 1'b0;
    rel  = cyc;
    base = upd_n;
    wait_lock("abort_lock", at);
    chk("abort_lock_cycle", at, rel + L);
    chk("abort_no_update", upd_n, base);
    chk("abort_cfg_m", cfg_m, 32'h00000404);
    chk("abort_cfg_c0", {14'b0, cfg_c0}, 32'h505);
    chk("abort_cfg_c1", {14'b0, cfg_c1}, 32'h0);
    chk("abort_cfg_mfrac", cfg_mfrac, 32'h9745BF27);
    bus_access(1'b0, 1'b1, 6'd4, 32'h0, 32'h00000404, "abort_m_shadow", w, a);
    bus_access(1'b0, 1'b1, 6'd0, 32'h0, 32'h0, "abort_mode", w, a);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
